// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cook_timer_ctrl
// Brief   : MM:SS BCD countdown cooking timer with set/run/pause/alarm FSM.
// Revision: 1.0
// ============================================================================
module cook_timer_ctrl #(
  parameter int MAX_MIN   = 59,
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_sec,
  input  logic       btn_inc_min,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic [1:0] state,
  output logic       running,
  output logic       alarm,
  output logic       alarm_start
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] c_MAX_M10    = 4'(MAX_MIN / 10);
  localparam logic [3:0] c_MAX_M1     = 4'(MAX_MIN % 10);
  localparam logic [7:0] c_ALARM_LAST = 8'(ALARM_SEC - 1);

  state_t     r_state, w_state;
  logic [3:0] r_m10, r_m1, r_s10, r_s1;
  logic [3:0] w_m10, w_m1, w_s10, w_s1;
  logic [7:0] r_cnt, w_cnt;
  logic       r_alarm_start, w_alarm_start;
  logic       w_zero, w_one;

  assign w_zero = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 4'd0) && (r_s1 == 4'd0);
  assign w_one  = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 4'd0) && (r_s1 == 4'd1);

  always_comb begin
    w_state       = r_state;
    w_m10         = r_m10;
    w_m1          = r_m1;
    w_s10         = r_s10;
    w_s1          = r_s1;
    w_cnt         = r_cnt;
    w_alarm_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (btn_clear) begin
          {w_m10, w_m1, w_s10, w_s1} = 16'h0000;
        end else if (btn_start) begin
          if (!w_zero) w_state = S_RUN;
        end else begin
          if (btn_inc_sec) begin
            if (r_s10 == 4'd5 && r_s1 == 4'd9) begin
              w_s10 = 4'd0;
              w_s1  = 4'd0;
            end else if (r_s1 == 4'd9) begin
              w_s1  = 4'd0;
              w_s10 = r_s10 + 4'd1;
            end else begin
              w_s1 = r_s1 + 4'd1;
            end
          end
          if (btn_inc_min) begin
            if (r_m10 == c_MAX_M10 && r_m1 == c_MAX_M1) begin
              w_m10 = 4'd0;
              w_m1  = 4'd0;
            end else if (r_m1 == 4'd9) begin
              w_m1  = 4'd0;
              w_m10 = r_m10 + 4'd1;
            end else begin
              w_m1 = r_m1 + 4'd1;
            end
          end
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          w_state = S_IDLE;
          {w_m10, w_m1, w_s10, w_s1} = 16'h0000;
        end else if (btn_start) begin
          w_state = S_PAUSE;
        end else if (clk_sec) begin
          if (w_one) begin
            w_s1          = 4'd0;
            w_state       = S_ALARM;
            w_cnt         = 8'd0;
            w_alarm_start = 1'b1;
          end else if (!w_zero) begin
            // Cascaded BCD borrow: each digit wraps only when the one below it does.
            if (r_s1 != 4'd0) begin
              w_s1 = r_s1 - 4'd1;
            end else begin
              w_s1 = 4'd9;
              if (r_s10 != 4'd0) begin
                w_s10 = r_s10 - 4'd1;
              end else begin
                w_s10 = 4'd5;
                if (r_m1 != 4'd0) begin
                  w_m1 = r_m1 - 4'd1;
                end else begin
                  w_m1  = 4'd9;
                  w_m10 = r_m10 - 4'd1;
                end
              end
            end
          end
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          w_state = S_IDLE;
          {w_m10, w_m1, w_s10, w_s1} = 16'h0000;
        end else if (btn_start) begin
          w_state = S_RUN;
        end
      end
      default: begin
        if (btn_clear || btn_start) begin
          w_state = S_IDLE;
        end else if (clk_sec) begin
          if (r_cnt == c_ALARM_LAST) w_state = S_IDLE;
          else w_cnt = r_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state       <= S_IDLE;
      r_m10         <= 4'd0;
      r_m1          <= 4'd0;
      r_s10         <= 4'd0;
      r_s1          <= 4'd0;
      r_cnt         <= 8'd0;
      r_alarm_start <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_m10         <= w_m10;
      r_m1          <= w_m1;
      r_s10         <= w_s10;
      r_s1          <= w_s1;
      r_cnt         <= w_cnt;
      r_alarm_start <= w_alarm_start;
    end
  end

  assign min10       = r_m10;
  assign min1        = r_m1;
  assign sec10       = r_s10;
  assign sec1        = r_s1;
  assign state       = r_state;
  assign running     = (r_state == S_RUN);
  assign alarm       = (r_state == S_ALARM);
  assign alarm_start = r_alarm_start;

endmodule
`default_nettype wire
